// File: rtl/cpu_cache_pkg.sv
// Shared types and address-field helpers for the set-associative data cache.
package cpu_cache_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } access_mode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WB_REQ  = 2'd1,
    RF_REQ  = 2'd2,
    RF_WAIT = 2'd3
  } miss_state_e;

  function automatic int off_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int idx_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int addr_width, input int num_sets, input int line_bytes);
    return addr_width - $clog2(num_sets) - $clog2(line_bytes);
  endfunction

  // A single-way cache still needs a 1-bit way/pointer field.
  function automatic int way_w(input int num_ways);
    return (num_ways > 1) ? $clog2(num_ways) : 1;
  endfunction

  // Byte-lane mask of an access, right-aligned.
  function automatic logic [3:0] size_mask(input access_mode_e mode);
    case (mode)
      BYTE:    return 4'b0001;
      HALF:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/cpu_cache_assoc_if.sv
// CPU request/response and memory-bus signals of the cache.
interface cpu_cache_assoc_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 16
);
  localparam int LADDR_W = ADDR_WIDTH - $clog2(LINE_BYTES);

  logic                    req_read;
  logic                    req_write;
  logic [1:0]              req_mode;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [31:0]             req_data;
  logic                    resp_hit;
  logic [31:0]             resp_data;
  logic                    resp_misaligned;
  logic                    busy;
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic                    mem_req_write;
  logic [LADDR_W-1:0]      mem_req_addr;
  logic [LINE_BYTES*8-1:0] mem_req_data;
  logic                    mem_resp_valid;
  logic [LINE_BYTES*8-1:0] mem_resp_data;

  // CPU plus memory model side.
  modport master (
    output req_read, req_write, req_mode, req_addr, req_data,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  resp_hit, resp_data, resp_misaligned, busy,
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_data
  );

  // Cache side.
  modport slave (
    input  req_read, req_write, req_mode, req_addr, req_data,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output resp_hit, resp_data, resp_misaligned, busy,
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_data
  );
endinterface

// File: rtl/cpu_cache_way_array.sv
// Tag/valid/dirty/data storage of one cache way: async read port plus a
// byte-enabled write port that either stores (sets dirty) or fills a line.
module cpu_cache_way_array #(
  parameter int NUM_SETS   = 4,
  parameter int TAG_W      = 26,
  parameter int LINE_BYTES = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [$clog2(NUM_SETS)-1:0] idx,
  output logic                        rd_valid,
  output logic                        rd_dirty,
  output logic [TAG_W-1:0]            rd_tag,
  output logic [LINE_BYTES*8-1:0]     rd_line,
  input  logic [LINE_BYTES-1:0]       wr_be,
  input  logic [LINE_BYTES*8-1:0]     wr_line,
  input  logic                        wr_store,
  input  logic                        wr_fill,
  input  logic [TAG_W-1:0]            wr_tag
);
  localparam int LINE_W = LINE_BYTES * 8;

  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [NUM_SETS-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [LINE_W-1:0]   data_q [NUM_SETS];
  logic [LINE_W-1:0]   line_d;

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = data_q[idx];

  // Status bits: a fill installs a clean valid line, a store marks it dirty.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (wr_fill) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end else if (wr_store) begin
      dirty_d[idx] = 1'b1;
    end
  end

  // Merge enabled byte lanes into the addressed line.
  always_comb begin
    line_d = data_q[idx];
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (wr_be[b]) line_d[b*8 +: 8] = wr_line[b*8 +: 8];
    end
  end

  // Status register with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: clocked blocks use <= only; = is reserved for combinational logic.
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data storage.
  always_ff @(posedge clock) begin
    // NOTE: tags and line data are deliberately not reset; valid_q guards them.
    if (wr_fill) tag_q[idx] <= wr_tag;
    if (|wr_be)  data_q[idx] <= line_d;
  end
endmodule

// File: rtl/cpu_cache_assoc.sv
// N-way set-associative write-back, write-allocate data cache with a
// blocking miss FSM (optional victim write-back, then refill).
module cpu_cache_assoc
  import cpu_cache_pkg::*;
#(
  parameter int NUM_SETS   = 4,
  parameter int NUM_WAYS   = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 16
) (
  input logic               clock,
  input logic               reset,
  cpu_cache_assoc_if.slave  bus
);
  localparam int OFF_W  = off_w(LINE_BYTES);
  localparam int IDX_W  = idx_w(NUM_SETS);
  localparam int TAG_W  = tag_w(ADDR_WIDTH, NUM_SETS, LINE_BYTES);
  localparam int WAY_W  = way_w(NUM_WAYS);
  localparam int LINE_W = LINE_BYTES * 8;

  miss_state_e      state_q, state_d;
  logic [TAG_W-1:0] miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0] miss_idx_q, miss_idx_d;
  logic [WAY_W-1:0] victim_q, victim_d;
  logic [WAY_W-1:0] rr_q [NUM_SETS];
  logic [WAY_W-1:0] rr_d [NUM_SETS];

  access_mode_e     mode;
  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx, arr_idx;
  logic [TAG_W-1:0] req_tag;
  logic             req_any, misaligned, lookup, hit_any, store_hit, fill;
  logic             mem_valid, mem_write;
  logic [WAY_W-1:0] hit_way, victim_sel;
  logic [LINE_W-1:0]     store_line;
  logic [LINE_BYTES-1:0] store_be;
  logic [31:0]           rd_word, rd_mask;
  logic [TAG_W+IDX_W-1:0] mem_addr;
  logic [LINE_W-1:0]      mem_data;

  logic [NUM_WAYS-1:0]   way_valid, way_dirty, way_store, way_fill;
  logic [TAG_W-1:0]      way_tag  [NUM_WAYS];
  logic [LINE_W-1:0]     way_line [NUM_WAYS];
  logic [LINE_BYTES-1:0] way_be   [NUM_WAYS];

  assign mode       = access_mode_e'(bus.req_mode);
  assign req_off    = bus.req_addr[OFF_W-1:0];
  assign req_idx    = bus.req_addr[OFF_W +: IDX_W];
  assign req_tag    = bus.req_addr[ADDR_WIDTH-1 -: TAG_W];
  assign req_any    = bus.req_read | bus.req_write;
  assign misaligned = ((mode == HALF) && bus.req_addr[0]) ||
                      ((mode == WORD) && (bus.req_addr[1:0] != 2'b00));
  assign lookup     = reset && (state_q == IDLE) && req_any && !misaligned;
  assign store_hit  = lookup && hit_any && bus.req_write;
  // The miss in flight owns the arrays; otherwise the live request does.
  assign arr_idx    = (state_q == IDLE) ? req_idx : miss_idx_q;
  assign store_line = LINE_W'(bus.req_data) << {req_off, 3'b000};
  assign store_be   = LINE_BYTES'(size_mask(mode)) << req_off;
  assign rd_word    = 32'(way_line[hit_way] >> {req_off, 3'b000});
  assign rd_mask    = (mode == BYTE) ? 32'h0000_00FF : (mode == HALF) ? 32'h0000_FFFF : 32'hFFFF_FFFF;

  for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
    cpu_cache_way_array #(.NUM_SETS(NUM_SETS), .TAG_W(TAG_W), .LINE_BYTES(LINE_BYTES)) u_way (
      .clock    (clock),
      .reset    (reset),
      .idx      (arr_idx),
      .rd_valid (way_valid[g]),
      .rd_dirty (way_dirty[g]),
      .rd_tag   (way_tag[g]),
      .rd_line  (way_line[g]),
      .wr_be    (way_be[g]),
      .wr_line  (fill ? bus.mem_resp_data : store_line),
      .wr_store (way_store[g]),
      .wr_fill  (way_fill[g]),
      .wr_tag   (miss_tag_q)
    );
  end

  // Tag compare and victim choice (lowest invalid way, else round-robin).
  always_comb begin
    hit_any    = 1'b0;
    hit_way    = '0;
    victim_sel = rr_q[req_idx];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) victim_sel = WAY_W'(w);
      if (way_valid[w] && (way_tag[w] == req_tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Per-way write steering for store hits and refills.
  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      way_store[w] = store_hit && (hit_way == WAY_W'(w));
      way_fill[w]  = fill && (victim_q == WAY_W'(w));
      way_be[w]    = way_fill[w] ? '1 : (way_store[w] ? store_be : '0);
    end
  end

  // Miss FSM next state, bus handshake and replacement pointer update.
  always_comb begin
    state_d    = state_q;
    miss_tag_d = miss_tag_q;
    miss_idx_d = miss_idx_q;
    victim_d   = victim_q;
    rr_d       = rr_q;
    fill       = 1'b0;
    mem_valid  = 1'b0;
    mem_write  = 1'b0;
    case (state_q)
      IDLE: begin
        if (lookup && !hit_any) begin
          miss_tag_d = req_tag;
          miss_idx_d = req_idx;
          victim_d   = victim_sel;
          state_d    = (way_valid[victim_sel] && way_dirty[victim_sel]) ? WB_REQ : RF_REQ;
        end
      end
      WB_REQ: begin
        mem_valid = 1'b1;
        mem_write = 1'b1;
        if (bus.mem_req_ready) state_d = RF_REQ;
      end
      RF_REQ: begin
        mem_valid = 1'b1;
        if (bus.mem_req_ready) state_d = RF_WAIT;
      end
      RF_WAIT: begin
        if (bus.mem_resp_valid && reset) begin
          fill             = 1'b1;
          rr_d[miss_idx_q] = (rr_q[miss_idx_q] == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_q[miss_idx_q] + 1'b1;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus address/data; held constant by the stable latched miss registers.
  always_comb begin
    mem_addr = '0;
    mem_data = '0;
    if (state_q == WB_REQ) begin
      mem_addr = {way_tag[victim_q], miss_idx_q};
      mem_data = way_line[victim_q];
    end else if (state_q == RF_REQ) begin
      mem_addr = {miss_tag_q, miss_idx_q};
    end
  end

  // Miss FSM and replacement pointer registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      victim_q   <= '0;
      for (int s = 0; s < NUM_SETS; s++) rr_q[s] <= '0;
    end else begin
      state_q    <= state_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
      victim_q   <= victim_d;
      rr_q       <= rr_d;
    end
  end

  assign bus.resp_hit        = lookup && hit_any;
  assign bus.resp_data       = (lookup && hit_any && !bus.req_write) ? (rd_word & rd_mask) : 32'h0;
  assign bus.resp_misaligned = reset && req_any && misaligned;
  assign bus.busy            = reset && (state_q != IDLE);
  assign bus.mem_req_valid   = reset && mem_valid;
  assign bus.mem_req_write   = reset && mem_write;
  assign bus.mem_req_addr    = reset ? mem_addr : '0;
  assign bus.mem_req_data    = reset ? mem_data : '0;
endmodule

// File: tb/tb_cpu_cache_assoc.sv
// Directed self-checking bench for cpu_cache_assoc (4 sets, 2 ways, 16-byte lines).
module tb_cpu_cache_assoc;
  import cpu_cache_pkg::*;

  localparam logic [127:0] LINE_A   = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
  localparam logic [127:0] LINE_MOD = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADABEF};
  localparam logic [127:0] LINE_B   = {32'h77777777, 32'h66666666, 32'h55555555, 32'hCAFEF00D};
  localparam logic [127:0] LINE_C   = {32'hAAAAAAAA, 32'h99999999, 32'h88888888, 32'h0BADF00D};
  localparam logic [127:0] LINE_D   = {32'hEEEEEEEE, 32'hDDDDDDDD, 32'hCCCCCCCC, 32'h600DCAFE};

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  cpu_cache_assoc_if #(.ADDR_WIDTH(32), .LINE_BYTES(16)) bus ();

  cpu_cache_assoc #(.NUM_SETS(4), .NUM_WAYS(2), .ADDR_WIDTH(32), .LINE_BYTES(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs are driven and outputs sampled just after the edge.
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    bus.req_read       = 1'b0;
    bus.req_write      = 1'b0;
    bus.req_mode       = 2'd0;
    bus.req_addr       = '0;
    bus.req_data       = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
  endtask

  task automatic set_req(input logic wr, input access_mode_e mode, input logic [31:0] addr, input logic [31:0] data);
    bus.req_read  = !wr;
    bus.req_write = wr;
    bus.req_mode  = mode;
    bus.req_addr  = addr;
    bus.req_data  = data;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_req(1'b0, WORD, 32'h102, 32'h0);
    cycle();
    cycle();
    checks++; if (bus.resp_hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %0b want 0", bus.resp_hit); end
    checks++; if (bus.resp_misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %0b want 0", bus.resp_misaligned); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %0b want 0", bus.mem_req_valid); end
    set_idle();
    reset = 1'b1;
    cycle();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %0b want 0", bus.busy); end
  endtask

  task automatic test_cold_miss();
    set_req(1'b0, WORD, 32'h100, 32'h0);
    #1;
    checks++; if (bus.resp_hit !== 1'b0) begin errors++; $display("FAIL cold_first_hit: got %0b want 0", bus.resp_hit); end
    checks++; if (bus.resp_misaligned !== 1'b0) begin errors++; $display("FAIL cold_misaligned: got %0b want 0", bus.resp_misaligned); end
    cycle();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL cold_busy: got %0b want 1", bus.busy); end
    checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_write !== 1'b0) begin errors++; $display("FAIL cold_rf_req: valid=%0b write=%0b want 1/0", bus.mem_req_valid, bus.mem_req_write); end
    checks++; if (bus.mem_req_addr !== 28'h10) begin errors++; $display("FAIL cold_rf_addr: got %h want 0000010", bus.mem_req_addr); end
    checks++; if (bus.resp_hit !== 1'b0) begin errors++; $display("FAIL cold_hit_while_busy: got %0b want 0", bus.resp_hit); end
    bus.mem_req_ready = 1'b1;
    cycle();
    bus.mem_req_ready = 1'b0;
    #1;
    checks++; if (bus.mem_req_valid !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL cold_rf_wait: valid=%0b busy=%0b want 0/1", bus.mem_req_valid, bus.busy); end
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = LINE_A;
    cycle();
    bus.mem_resp_valid = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL cold_done_busy: got %0b want 0", bus.busy); end
    checks++; if (bus.resp_hit !== 1'b1 || bus.resp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL cold_retry: hit=%0b data=%h want 1/deadbeef", bus.resp_hit, bus.resp_data); end
    set_req(1'b0, BYTE, 32'h103, 32'h0);
    #1;
    checks++; if (bus.resp_hit !== 1'b1 || bus.resp_data !== 32'h000000DE) begin errors++; $display("FAIL cold_byte_read: hit=%0b data=%h want 1/000000de", bus.resp_hit, bus.resp_data); end
    set_req(1'b0, HALF, 32'h106, 32'h0);
    #1;
    checks++; if (bus.resp_hit !== 1'b1 || bus.resp_data !== 32'h00001111) begin errors++; $display("FAIL cold_half_read: hit=%0b data=%h want 1/00001111", bus.resp_hit, bus.resp_data); end
    cycle();
  endtask

  task automatic test_byte_store();
    // Read and write both high: the write must win.
    set_req(1'b1, BYTE, 32'h101, 32'h123456AB);
    bus.req_read = 1'b1;
    #1;
    checks++; if (bus.resp_hit !== 1'b1) begin errors++; $display("FAIL store_hit: got %0b want 1", bus.resp_hit); end
    cycle();
    set_req(1'b0, WORD, 32'h100, 32'h0);
    #1;
    checks++; if (bus.resp_hit !== 1'b1 || bus.resp_data !== 32'hDEADABEF) begin errors++; $display("FAIL store_readback: hit=%0b data=%h want 1/deadabef", bus.resp_hit, bus.resp_data); end
    cycle();
  endtask

  task automatic test_misaligned();
    set_req(1'b0, WORD, 32'h102, 32'h0);
    #1;
    checks++; if (bus.resp_misaligned !== 1'b1 || bus.resp_hit !== 1'b0) begin errors++; $display("FAIL mis_word: mis=%0b hit=%0b want 1/0", bus.resp_misaligned, bus.resp_hit); end
    cycle();
    checks++; if (bus.mem_req_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mis_word_nomiss: valid=%0b busy=%0b want 0/0", bus.mem_req_valid, bus.busy); end
    set_req(1'b1, HALF, 32'h105, 32'h0000FFFF);
    #1;
    checks++; if (bus.resp_misaligned !== 1'b1 || bus.resp_hit !== 1'b0) begin errors++; $display("FAIL mis_half: mis=%0b hit=%0b want 1/0", bus.resp_misaligned, bus.resp_hit); end
    cycle();
    checks++; if (bus.mem_req_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mis_half_nomiss: valid=%0b busy=%0b want 0/0", bus.mem_req_valid, bus.busy); end
    set_req(1'b0, HALF, 32'h104, 32'h0);
    #1;
    checks++; if (bus.resp_hit !== 1'b1 || bus.resp_data !== 32'h00001111) begin errors++; $display("FAIL mis_no_write: hit=%0b data=%h want 1/00001111", bus.resp_hit, bus.resp_data); end
    cycle();
  endtask

  task automatic test_eviction_backpressure();
    set_req(1'b0, WORD, 32'h140, 32'h0);
    #1;
    checks++; if (bus.resp_hit !== 1'b0) begin errors++; $display("FAIL evict_fill_miss: got %0b want 0", bus.resp_hit); end
    cycle();
    checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_write !== 1'b0 || bus.mem_req_addr !== 28'h14) begin errors++; $display("FAIL evict_fill_req: valid=%0b write=%0b addr=%h want 1/0/0000014", bus.mem_req_valid, bus.mem_req_write, bus.mem_req_addr); end
    bus.mem_req_ready = 1'b1;
    cycle();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = LINE_B;
    cycle();
    bus.mem_resp_valid = 1'b0;
    #1;
    checks++; if (bus.resp_hit !== 1'b1 || bus.resp_data !== 32'hCAFEF00D) begin errors++; $display("FAIL evict_fill_hit: hit=%0b data=%h want 1/cafef00d", bus.resp_hit, bus.resp_data); end
    set_req(1'b0, WORD, 32'h180, 32'h0);
    #1;
    checks++; if (bus.resp_hit !== 1'b0) begin errors++; $display("FAIL evict_miss: got %0b want 0", bus.resp_hit); end
    cycle();
    checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_write !== 1'b1 || bus.mem_req_addr !== 28'h10 || bus.mem_req_data !== LINE_MOD) begin errors++; $display("FAIL evict_wb: valid=%0b write=%0b addr=%h data=%h want 1/1/0000010/%h", bus.mem_req_valid, bus.mem_req_write, bus.mem_req_addr, bus.mem_req_data, LINE_MOD); end
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_write !== 1'b1 || bus.mem_req_addr !== 28'h10 || bus.mem_req_data !== LINE_MOD || bus.busy !== 1'b1) begin errors++; $display("FAIL backpressure_%0d: valid=%0b write=%0b addr=%h data=%h busy=%0b", i, bus.mem_req_valid, bus.mem_req_write, bus.mem_req_addr, bus.mem_req_data, bus.busy); end
    end
    bus.mem_req_ready = 1'b1;
    cycle();
    bus.mem_req_ready = 1'b0;
    #1;
    checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_write !== 1'b0 || bus.mem_req_addr !== 28'h18) begin errors++; $display("FAIL evict_rf_req: valid=%0b write=%0b addr=%h want 1/0/0000018", bus.mem_req_valid, bus.mem_req_write, bus.mem_req_addr); end
    bus.mem_req_ready = 1'b1;
    cycle();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = LINE_C;
    cycle();
    bus.mem_resp_valid = 1'b0;
    #1;
    checks++; if (bus.resp_hit !== 1'b1 || bus.resp_data !== 32'h0BADF00D) begin errors++; $display("FAIL evict_retry: hit=%0b data=%h want 1/0badf00d", bus.resp_hit, bus.resp_data); end
    set_req(1'b0, WORD, 32'h140, 32'h0);
    #1;
    checks++; if (bus.resp_hit !== 1'b1 || bus.resp_data !== 32'hCAFEF00D) begin errors++; $display("FAIL evict_kept_way1: hit=%0b data=%h want 1/cafef00d", bus.resp_hit, bus.resp_data); end
    cycle();
  endtask

  task automatic test_replacement();
    // Pointer is 1 after the previous refill, so the clean way1 (0x140) goes.
    set_req(1'b0, WORD, 32'h1C0, 32'h0);
    #1;
    checks++; if (bus.resp_hit !== 1'b0) begin errors++; $display("FAIL rr_miss: got %0b want 0", bus.resp_hit); end
    cycle();
    checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_write !== 1'b0 || bus.mem_req_addr !== 28'h1C) begin errors++; $display("FAIL rr_rf_req: valid=%0b write=%0b addr=%h want 1/0/000001c", bus.mem_req_valid, bus.mem_req_write, bus.mem_req_addr); end
    // Request change and a stray response while not in RF_WAIT are both ignored.
    bus.req_addr       = 32'h200;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = LINE_A;
    cycle();
    bus.mem_resp_valid = 1'b0;
    #1;
    checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_write !== 1'b0 || bus.mem_req_addr !== 28'h1C || bus.busy !== 1'b1) begin errors++; $display("FAIL rr_stray_ignored: valid=%0b write=%0b addr=%h busy=%0b want 1/0/000001c/1", bus.mem_req_valid, bus.mem_req_write, bus.mem_req_addr, bus.busy); end
    bus.req_addr      = 32'h1C0;
    bus.mem_req_ready = 1'b1;
    cycle();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = LINE_D;
    cycle();
    bus.mem_resp_valid = 1'b0;
    #1;
    checks++; if (bus.resp_hit !== 1'b1 || bus.resp_data !== 32'h600DCAFE) begin errors++; $display("FAIL rr_retry: hit=%0b data=%h want 1/600dcafe", bus.resp_hit, bus.resp_data); end
    set_req(1'b0, WORD, 32'h180, 32'h0);
    #1;
    checks++; if (bus.resp_hit !== 1'b1 || bus.resp_data !== 32'h0BADF00D) begin errors++; $display("FAIL rr_way0_kept: hit=%0b data=%h want 1/0badf00d", bus.resp_hit, bus.resp_data); end
    cycle();
  endtask

  task automatic test_reset_mid_miss();
    set_req(1'b0, WORD, 32'h140, 32'h0);
    #1;
    checks++; if (bus.resp_hit !== 1'b0) begin errors++; $display("FAIL rst_evicted_miss: got %0b want 0", bus.resp_hit); end
    cycle();
    checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 28'h14) begin errors++; $display("FAIL rst_rf_req: valid=%0b addr=%h want 1/0000014", bus.mem_req_valid, bus.mem_req_addr); end
    bus.mem_req_ready = 1'b1;
    cycle();
    bus.mem_req_ready = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b1 || bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_in_rf_wait: busy=%0b valid=%0b want 1/0", bus.busy, bus.mem_req_valid); end
    set_idle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_after: busy=%0b valid=%0b want 0/0", bus.busy, bus.mem_req_valid); end
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = LINE_B;
    cycle();
    bus.mem_resp_valid = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_late_resp_busy: got %0b want 0", bus.busy); end
    set_req(1'b0, WORD, 32'h140, 32'h0);
    #1;
    checks++; if (bus.resp_hit !== 1'b0) begin errors++; $display("FAIL rst_late_resp_ignored: hit=%0b want 0", bus.resp_hit); end
    set_req(1'b0, WORD, 32'h100, 32'h0);
    #1;
    checks++; if (bus.resp_hit !== 1'b0) begin errors++; $display("FAIL rst_0x100_miss: hit=%0b want 0", bus.resp_hit); end
    set_req(1'b0, WORD, 32'h180, 32'h0);
    #1;
    checks++; if (bus.resp_hit !== 1'b0) begin errors++; $display("FAIL rst_0x180_miss: hit=%0b want 0", bus.resp_hit); end
    cycle();
    checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_write !== 1'b0 || bus.mem_req_addr !== 28'h18) begin errors++; $display("FAIL rst_new_miss: valid=%0b write=%0b addr=%h want 1/0/0000018", bus.mem_req_valid, bus.mem_req_write, bus.mem_req_addr); end
    set_idle();
  endtask

  initial begin
    set_idle();
    reset = 1'b0;
    #1;
    test_reset();
    test_cold_miss();
    test_byte_store();
    test_misaligned();
    test_eviction_backpressure();
    test_replacement();
    test_reset_mid_miss();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_cache_assoc.md
Name: cpu_cache_assoc

Overview:
Parametrised N-way set-associative, write-back, write-allocate data cache; the successor to the direct-mapped line cache.
Sits between the CPU load/store stage and the memory bus.
Hits are answered combinationally in the request cycle. Misses run a blocking miss FSM: optional victim write-back, then line refill.
Supports BYTE/HALF/WORD accesses, per-set round-robin replacement and misalignment detection.

Parameters:
NUM_SETS, 4, number of sets (power of 2, >=2)
NUM_WAYS, 2, ways per set (power of 2, >=1)
ADDR_WIDTH, 32, physical byte-address width
LINE_BYTES, 16, bytes per line (power of 2, >=4)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
req_read  in  1  load request
req_write  in  1  store request; wins if both read and write are high
req_mode  in  2  access size: BYTE=0, HALF=1, WORD=2
req_addr  in  ADDR_WIDTH  byte address
req_data  in  32  store data, right-aligned
resp_hit  out  1  request completed this cycle
resp_data  out  32  load data, zero-extended, right-aligned
resp_misaligned  out  1  HALF with addr[0]!=0, or WORD with addr[1:0]!=0
busy  out  1  miss FSM not IDLE
mem_req_valid  out  1  bus request valid
mem_req_ready  in  1  bus accepts the request on valid&&ready
mem_req_write  out  1  1=write-back, 0=refill read
mem_req_addr  out  ADDR_WIDTH-log2(LINE_BYTES)  line address
mem_req_data  out  LINE_BYTES*8  victim line (write-back only)
mem_resp_valid  in  1  refill data valid
mem_resp_data  in  LINE_BYTES*8  refill line

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is synchronous and active-low: reset==0 at a rising edge clears state.
- Reset effects: all valid and dirty bits cleared, round-robin pointers cleared to 0, FSM to IDLE.
  - Outputs are 0 during and after reset; line data is not reset.
- Address split: offset = addr[log2(LINE_BYTES)-1:0], index = next log2(NUM_SETS) bits, tag = the remaining upper bits.
- Hit: a way in the indexed set has valid && tag match. Hit logic is combinational and active only when FSM is IDLE and the access is aligned.
- Read hit: resp_hit=1 in the same cycle; resp_data carries the selected byte/half/word, zero-extended.
- Write hit: resp_hit=1 in the same cycle. At the next edge the addressed bytes are written and the line's dirty bit is set.
- Misaligned request: resp_misaligned=1, resp_hit=0. No state change and no miss is started.
- Miss (IDLE, aligned, no hit):
  - resp_hit=0.
  - Address and victim way are latched.
  - FSM moves to WB_REQ if the victim is valid&&dirty, else to RF_REQ.
  - The requester must hold and retry the request.
- Victim choice: lowest-index invalid way; otherwise the set's round-robin pointer.
- FSM states:
  - IDLE: no bus activity.
  - WB_REQ: mem_req_valid=1, mem_req_write=1, addr={victim tag,index}, data=victim line. Advances to RF_REQ on ready.
  - RF_REQ: mem_req_valid=1, mem_req_write=0, addr=latched line address. Advances to RF_WAIT on ready.
  - RF_WAIT: waits for mem_resp_valid.
    - On mem_resp_valid, the victim way takes the data, tag, valid=1, dirty=0.
    - The set pointer increments, wrapping modulo NUM_WAYS.
    - FSM returns to IDLE. The retried request hits on the following cycle.
- Bus stability: mem_req_addr, mem_req_data and mem_req_write stay stable while valid&&!ready.
- Request changes mid-miss: ignored; the latched miss completes.
- mem_resp_valid outside RF_WAIT: ignored, with no state change.
- Reset asserted in any state: FSM returns to IDLE and busy=0 / mem_req_valid=0 from the next cycle. A late mem_resp_valid is then ignored.
- busy=1 in every non-IDLE state; resp_hit=0 whenever busy.

Decomposition:
- Shared package cpu_cache_pkg holds:
  - access_mode_e (BYTE/HALF/WORD)
  - miss_state_e (IDLE, WB_REQ, RF_REQ, RF_WAIT)
  - address-field width functions
- Sub-module cpu_cache_way_array: the tag/valid/dirty/data storage for one way. It is instantiated NUM_WAYS times and provides a read port plus a byte-enabled write port.
- Miss FSM and replacement pointers live in the top level.

Test Plan:
Defaults: NUM_SETS=4, NUM_WAYS=2, LINE_BYTES=16.
1. Cold miss: after reset, WORD read at 0x100 -> resp_hit=0. Next cycle mem_req_valid=1, write=0, addr=0x10. Grant ready, return data with word0=0xDEADBEEF -> retried read hits with resp_data=0xDEADBEEF.
2. Byte store: BYTE write 0xAB at 0x101 after test 1 -> resp_hit=1. WORD read at 0x100 -> 0xDEADABEF. Line is dirty.
3. Eviction: fill 0x140 (set 0, way1), then read 0x180 -> WB_REQ with addr=0x10 and data holding the modified line. Then RF_REQ with addr=0x18, installed into way0; pointer then equals 1.
4. Backpressure: mem_req_ready=0 for 5 cycles in WB_REQ -> valid, addr, data and write constant across all 5 cycles; FSM advances only on the ready cycle.
5. Misalignment: WORD read at 0x102 and HALF write at 0x105 -> resp_misaligned=1, resp_hit=0, no mem_req_valid, no dirty change.
6. Reset in RF_WAIT: reset=0 for one cycle -> busy=0, all ways invalid. A later mem_resp_valid is ignored, and a read at 0x100 misses again.
